// File: rtl/cpu_fetch_s_if.sv
// cpu_fetch_s_if: fetch <-> L1 instruction cache request/ack bus.
//   if_il1_req    fetch -> cache  request, held with address until acked
//   if_il1_addr   fetch -> cache  word-aligned fetch address
//   if_il1_ack    cache -> fetch  ack, if_il1_rdata valid in the same cycle
//   if_il1_rdata  cache -> fetch  instruction word
interface cpu_fetch_s_if;
  logic        if_il1_req;
  logic [31:0] if_il1_addr;
  logic        if_il1_ack;
  logic [31:0] if_il1_rdata;

  modport master (output if_il1_req, if_il1_addr, input if_il1_ack, if_il1_rdata);
  modport slave  (input if_il1_req, if_il1_addr, output if_il1_ack, if_il1_rdata);
endinterface

// File: rtl/cpu_fetch_s.sv
// cpu_fetch_s: instruction fetch stage. Owns the PC, fetches words from the
// L1 I-cache over a req/ack handshake and loads the fetch/decode register.
// Handles execute redirects (kill + wrong-path drop) and downstream stall.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   il1                 I-cache bus (master side of cpu_fetch_s_if)
//   if_stall_in         decode stalled, fetch/decode register holds
//   if_brnch_taken/tgt  redirect pulse and target PC
//   if_inst_out_r, if_pc_out_r, if_pc_4_out_r, if_valid_out_r  decode slot
//   if_kill_out         registered copy of the redirect pulse
//   if_misalign_r       (CPU_IF_MISALIGN_CHK_EN only) sticky misaligned-target flag
// Build option: define CPU_IF_MISALIGN_CHK_EN to halt fetch on a misaligned
// redirect target; otherwise target bits [1:0] are simply cleared.
module cpu_fetch_s #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst_n,
  cpu_fetch_s_if.master      il1,
  input  logic               if_stall_in,
  input  logic               if_brnch_taken,
  input  logic [31:0]        if_brnch_tgt,
  output logic [31:0]        if_inst_out_r,
  output logic [31:0]        if_pc_out_r,
  output logic [31:0]        if_pc_4_out_r,
  output logic               if_valid_out_r,
`ifdef CPU_IF_MISALIGN_CHK_EN
  output logic               if_misalign_r,
`endif
  output logic               if_kill_out
);

  typedef enum logic [1:0] {RUN, SKID, DROP} state_e;

  state_e      state_r, state_nxt;
  logic [31:0] pc_r, pc_nxt;
  logic [31:0] drop_addr_r, drop_addr_nxt;   // address of the request being discarded
  logic [31:0] skid_inst_r, skid_inst_nxt;
  logic [31:0] skid_pc_r, skid_pc_nxt;
  logic        pend_r, pend_nxt;             // request raised last cycle, not yet acked
  logic        started_r;                    // holds req low through the reset-release cycle
  logic [31:0] inst_nxt, pc_out_nxt, pc_4_nxt;
  logic        valid_nxt;
  logic        req, ack_v, fetch_en;
  logic [31:0] addr, redirect_pc;

`ifdef CPU_IF_MISALIGN_CHK_EN
  logic misalign_hit, misalign_nxt;
  assign misalign_hit = if_brnch_taken & (|if_brnch_tgt[1:0]);
  assign misalign_nxt = if_misalign_r | misalign_hit;
  // A misaligned target still kills, but the PC stays put and fetch parks.
  assign redirect_pc  = misalign_hit ? pc_r : if_brnch_tgt;
  assign fetch_en     = ~if_misalign_r;
`else
  assign redirect_pc  = if_brnch_tgt & ~32'h3;
  assign fetch_en     = 1'b1;
`endif

  always_comb begin
    req = 1'b0;
    unique case (state_r)
      // A raised request is never retracted, so pend_r overrides stall/halt.
      RUN:     req = started_r & (pend_r | (fetch_en & ~(if_stall_in & if_valid_out_r)));
      SKID:    req = 1'b0;
      DROP:    req = 1'b1;
      default: req = 1'b0;
    endcase
  end

  assign addr  = (state_r == DROP) ? drop_addr_r : pc_r;
  assign ack_v = req & il1.if_il1_ack;
  assign il1.if_il1_req  = req;
  assign il1.if_il1_addr = addr;

  always_comb begin
    state_nxt     = state_r;
    pc_nxt        = pc_r;
    drop_addr_nxt = drop_addr_r;
    skid_inst_nxt = skid_inst_r;
    skid_pc_nxt   = skid_pc_r;
    pend_nxt      = pend_r;
    inst_nxt      = if_inst_out_r;
    pc_out_nxt    = if_pc_out_r;
    pc_4_nxt      = if_pc_4_out_r;
    valid_nxt     = if_valid_out_r;
    if (if_brnch_taken) begin
      // Redirect wins over ack, stall and skid; skid contents are abandoned.
      pc_nxt    = redirect_pc;
      valid_nxt = 1'b0;
      inst_nxt  = NOP_INST;
      pend_nxt  = 1'b0;
      if (req & ~il1.if_il1_ack) begin
        state_nxt     = DROP;
        drop_addr_nxt = addr;
      end else begin
        state_nxt = RUN;
      end
    end else begin
      unique case (state_r)
        RUN: begin
          pend_nxt = req & ~il1.if_il1_ack;
          if (ack_v) begin
            pc_nxt = pc_r + 32'd4;
            if (!if_stall_in) begin
              inst_nxt   = il1.if_il1_rdata;
              pc_out_nxt = pc_r;
              pc_4_nxt   = pc_r + 32'd4;
              valid_nxt  = 1'b1;
            end else begin
              skid_inst_nxt = il1.if_il1_rdata;
              skid_pc_nxt   = pc_r;
              state_nxt     = SKID;
            end
          end else if (!if_stall_in) begin
            valid_nxt = 1'b0;
            inst_nxt  = NOP_INST;
          end
        end
        SKID: begin
          if (!if_stall_in) begin
            inst_nxt   = skid_inst_r;
            pc_out_nxt = skid_pc_r;
            pc_4_nxt   = skid_pc_r + 32'd4;
            valid_nxt  = 1'b1;
            state_nxt  = RUN;
          end
        end
        DROP: begin
          if (ack_v) state_nxt = RUN;
          if (!if_stall_in) begin
            valid_nxt = 1'b0;
            inst_nxt  = NOP_INST;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= RUN;
      pc_r           <= RESET_PC;
      drop_addr_r    <= '0;
      skid_inst_r    <= '0;
      skid_pc_r      <= '0;
      pend_r         <= 1'b0;
      started_r      <= 1'b0;
      if_inst_out_r  <= NOP_INST;
      if_pc_out_r    <= '0;
      if_pc_4_out_r  <= '0;
      if_valid_out_r <= 1'b0;
      if_kill_out    <= 1'b0;
`ifdef CPU_IF_MISALIGN_CHK_EN
      if_misalign_r  <= 1'b0;
`endif
    end else begin
      state_r        <= state_nxt;
      pc_r           <= pc_nxt;
      drop_addr_r    <= drop_addr_nxt;
      skid_inst_r    <= skid_inst_nxt;
      skid_pc_r      <= skid_pc_nxt;
      pend_r         <= pend_nxt;
      started_r      <= 1'b1;
      if_inst_out_r  <= inst_nxt;
      if_pc_out_r    <= pc_out_nxt;
      if_pc_4_out_r  <= pc_4_nxt;
      if_valid_out_r <= valid_nxt;
      if_kill_out    <= if_brnch_taken;
`ifdef CPU_IF_MISALIGN_CHK_EN
      if_misalign_r  <= misalign_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_cpu_fetch_s.sv
// Randomized bench for cpu_fetch_s: random-latency I-cache, random stalls and
// redirects, checked against a transaction-level model (expected fetch address
// stream and an in-order queue of words owed to decode).
module tb_cpu_fetch_s;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, br = 1'b0;
  logic [31:0] tgt = '0;
  logic [31:0] inst_o, pc_o, pc4_o;
  logic        valid_o, kill_o;
`ifdef CPU_IF_MISALIGN_CHK_EN
  logic        misalign;
`endif

  always #5 clk = ~clk;

  cpu_fetch_s_if il1();

  cpu_fetch_s dut (
    .clk(clk), .rst_n(rst_n), .il1(il1),
    .if_stall_in(stall), .if_brnch_taken(br), .if_brnch_tgt(tgt),
    .if_inst_out_r(inst_o), .if_pc_out_r(pc_o), .if_pc_4_out_r(pc4_o),
    .if_valid_out_r(valid_o),
`ifdef CPU_IF_MISALIGN_CHK_EN
    .if_misalign_r(misalign),
`endif
    .if_kill_out(kill_o)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Cache contents: any fixed function of the address.
  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Stimulus knobs
  int p_stall = 0, p_br = 0, p_spur = 0, min_lat = 0, max_lat = 0;
  logic force_br = 1'b0, force_stall = 1'b0;
  logic [31:0] force_tgt = '0;

  // Cache model
  logic busy = 1'b0;
  int   lat = 0;

  // Reference model
  logic [31:0] q[$];          // words owed to decode, oldest first
  logic [31:0] exp_req = '0;  // next address a kept fetch must use
  logic        drop = 1'b0;   // the outstanding request is on the wrong path
  logic        prev_pend = 1'b0, br_prev = 1'b0;
  logic [31:0] prev_addr = '0;
  int          delivered = 0;

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF0;  // exercises PC wrap
    else t = $urandom_range(0, 1023) << 2;
`ifndef CPU_IF_MISALIGN_CHK_EN
    t = t | $urandom_range(0, 3);
`endif
    return t;
  endfunction

  task automatic sample();
    logic        req, ack;
    logic [31:0] addr, a;
    req  = il1.if_il1_req;
    ack  = il1.if_il1_ack;
    addr = il1.if_il1_addr;
    if (prev_pend) begin
      chk("req_hold", req, 1);
      chk("addr_hold", addr, prev_addr);
    end
    if (req) chk("addr_align", addr & 32'h3, 0);
    chk("kill", kill_o, br_prev);
    if (br_prev) chk("valid_after_kill", valid_o, 0);
    // Slot visible now is taken by decode at the coming edge unless stalled.
    if (valid_o && !stall) begin
      if (q.size() == 0) chk("deliver_extra", 1, 0);
      else begin
        a = q.pop_front();
        chk("out_pc", pc_o, a);
        chk("out_inst", inst_o, word(a));
        chk("out_pc4", pc4_o, a + 32'd4);
        delivered++;
      end
    end
    if (req && ack) begin
      if (drop) drop = 1'b0;
      else begin
        chk("req_addr", addr, exp_req);
        if (!br) q.push_back(addr);
        exp_req = exp_req + 32'd4;
      end
    end
    if (br) begin
      q.delete();
      exp_req = tgt & ~32'h3;
      if (req && !ack) drop = 1'b1;
    end
    prev_pend = req && !ack;
    prev_addr = addr;
    br_prev   = br;
  endtask

  task automatic step();
    @(posedge clk); #1;
    stall = force_stall ? 1'b1 : ($urandom_range(0, 99) < p_stall);
    if (force_br) begin br = 1'b1; tgt = force_tgt; end
    else if ($urandom_range(0, 99) < p_br) begin br = 1'b1; tgt = rand_tgt(); end
    else br = 1'b0;
    force_br = 1'b0;
    force_stall = 1'b0;
    #1;
    if (il1.if_il1_req) begin
      if (!busy) begin busy = 1'b1; lat = $urandom_range(min_lat, max_lat); end
      if (lat == 0) begin
        il1.if_il1_ack = 1'b1;
        il1.if_il1_rdata = word(il1.if_il1_addr);
        busy = 1'b0;
      end else begin
        lat--;
        il1.if_il1_ack = 1'b0;
        il1.if_il1_rdata = $urandom;
      end
    end else begin
      il1.if_il1_ack = ($urandom_range(0, 99) < p_spur);  // must be ignored
      il1.if_il1_rdata = $urandom;
    end
    #1;
    sample();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; stall = 1'b0; br = 1'b0;
    il1.if_il1_ack = 1'b0; il1.if_il1_rdata = '0;
    #2;
    chk("rst_req", il1.if_il1_req, 0);
    chk("rst_inst", inst_o, NOP);
    chk("rst_pc", pc_o, 0);
    chk("rst_pc4", pc4_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_kill", kill_o, 0);
`ifdef CPU_IF_MISALIGN_CHK_EN
    chk("rst_misalign", misalign, 0);
`endif
    q.delete();
    exp_req = '0; drop = 1'b0; prev_pend = 1'b0; br_prev = 1'b0; busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    il1.if_il1_ack = 1'b0;
    il1.if_il1_rdata = '0;
    do_reset();

    // Zero-wait cache: one fetch per cycle, slot valid from the second cycle.
    for (int i = 0; i < 4; i++) begin
      step();
      chk("zw_req", il1.if_il1_req, 1);
      chk("zw_addr", il1.if_il1_addr, 32'(i * 4));
      chk("zw_valid", valid_o, (i >= 1));
    end

    // Slow cache, then stalls.
    min_lat = 0; max_lat = 3; run(60);
    p_stall = 40; max_lat = 2; run(200);

    // Redirect to 0x100 while a slow request is outstanding.
    p_stall = 0; min_lat = 2; max_lat = 2;
    for (int k = 0; k < 20 && !busy; k++) step();
    force_br = 1'b1; force_tgt = 32'h100;
    step();
    step();
    chk("kill_pulse", kill_o, 1);
    step();
    chk("kill_once", kill_o, 0);
    run(10);

    // Redirect in the same cycle as a zero-wait ack under stall.
    min_lat = 0; max_lat = 0;
    force_br = 1'b1; force_stall = 1'b1; force_tgt = 32'h200;
    step();
    run(10);

    // Mixed random traffic, then reset with traffic in flight.
    p_stall = 30; p_br = 8; p_spur = 5; min_lat = 0; max_lat = 3;
    run(2000);
    do_reset();
    run(300);

    // Misaligned redirect target.
    p_stall = 0; p_br = 0; p_spur = 0; min_lat = 0; max_lat = 0;
    run(3);
    force_br = 1'b1; force_tgt = 32'h102;
    step();
`ifdef CPU_IF_MISALIGN_CHK_EN
    for (int k = 0; k < 10 && drop; k++) step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("halt_req", il1.if_il1_req, 0);
      chk("misalign", misalign, 1);
    end
`else
    begin
      bit found = 0;
      for (int k = 0; k < 10 && !found; k++) begin
        step();
        if (il1.if_il1_req && !drop) found = 1;
      end
      if (!found) chk("mis_timeout", 0, 1);
      else chk("mis_addr", il1.if_il1_addr, 32'h100);
    end
`endif

    chk("delivered_some", (delivered > 200), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
